// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch front end.
//   IMEM_BASE_ADDR : PC the fetch stream starts from after reset
//   NOP_INSN       : instruction presented to decode when nothing is valid
//   fq_entry_t     : one buffered {pc, insn} pair
package fetch_queue_pkg;
  localparam int FQ_AWIDTH = 32;
  localparam int FQ_DWIDTH = 32;

  localparam logic [FQ_AWIDTH-1:0] IMEM_BASE_ADDR = 32'h0100_0000;
  localparam logic [FQ_DWIDTH-1:0] NOP_INSN       = 32'h0000_0013;

  typedef struct packed {
    logic [FQ_AWIDTH-1:0] pc;
    logic [FQ_DWIDTH-1:0] insn;
  } fq_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH x fq_entry_t ring with read/write pointers and count.
//   clk, rst_n  : clock, async active-low reset
//   push, entry_i : write entry_i at the tail
//   pop         : retire the head entry
//   flush       : drop all entries (wins over push; a same-cycle pop is harmless)
//   head_o      : entry at the head (meaningful when count_o != 0)
//   count_o     : occupied entries
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  fq_entry_t       entry_i,
  input  logic            pop,
  input  logic            flush,
  output fq_entry_t       head_o,
  output logic [CW-1:0]   count_o
);

  fq_entry_t         mem_q [DEPTH];
  fq_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_eff;

  assign push_eff = push & ~flush;

  always_comb begin
    mem_d = mem_q;
    if (push_eff) mem_d[wr_ptr_q] = entry_i;
  end

  // Flush realigns the read pointer to the write pointer instead of
  // zeroing both, so no storage needs touching.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_eff);
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push_eff) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Credit accounting upstream makes these unreachable.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_eff && !pop && count_q == CW'(DEPTH)));
      assert (!(pop && count_q == '0));
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// PC generator plus prefetch FIFO between a 1-cycle synchronous-read imem
// and decode.
//   clk, rst        : clock, async active-low reset
//   imem_addr_o     : imem read address
//   imem_read_en_o  : imem read request this cycle
//   imem_data_i     : imem data, valid the cycle after a request
//   redirect_i      : flush and restart fetch at redirect_pc_i (word aligned)
//   valid_o/ready_i : head-entry handshake to decode
//   pc_o, insn_o    : head entry (0 / NOP when not valid)
//   count_o         : occupied FIFO entries
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                AWIDTH         = 32,
  parameter int                DWIDTH         = 32,
  parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = 32'h0100_0000,
  parameter int                DEPTH          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [AWIDTH-1:0]          imem_addr_o,
  output logic                       imem_read_en_o,
  input  logic [DWIDTH-1:0]          imem_data_i,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [AWIDTH-1:0]          pc_o,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;

  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              pop, push, issue;
  fq_entry_t         head, entry_in;
  logic              unused_rpc;

  assign unused_rpc = ^redirect_pc_i[1:0];

  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i;

  // The in-flight read already owns a slot, so it counts against capacity.
  // At exactly full a pop frees the slot that this cycle's request needs.
  // Issue is masked during reset so no request escapes before release.
  always_comb begin
    occ   = {1'b0, count} + (CW+1)'(inflight_q);
    issue = rst & (redirect_i | (occ < (CW+1)'(DEPTH)) |
                   ((occ == (CW+1)'(DEPTH)) & pop));
  end

  assign imem_read_en_o = issue;
  assign imem_addr_o    = redirect_i ? {redirect_pc_i[AWIDTH-1:2], 2'b00} : fetch_pc_q;

  always_comb begin
    fetch_pc_d = issue ? imem_addr_o + AWIDTH'(4) : fetch_pc_q;
    req_pc_d   = issue ? imem_addr_o : req_pc_q;
    inflight_d = issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= IMEM_BASE_ADDR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // A response landing alongside a redirect belongs to the old stream.
  assign push     = inflight_q & ~redirect_i;
  assign entry_in = '{pc: req_pc_q, insn: imem_data_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (push),
    .entry_i (entry_in),
    .pop     (pop),
    .flush   (redirect_i),
    .head_o  (head),
    .count_o (count)
  );

  assign count_o = count;
  assign pc_o    = valid_o ? head.pc   : '0;
  assign insn_o  = valid_o ? head.insn : NOP_INSN;

endmodule
